// File: rtl/fp32_pkg.sv
// Shared fp32 definitions: field widths, special encodings, classifiers and the divider state enum.
// Combinational helpers only. They carry no state and have no flow control.
package fp32_pkg;
  localparam int          EXP_W   = 8;
  localparam int          MANT_W  = 23;
  localparam int          BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7FC00001;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV,
    S_PACK,
    S_DONE
  } state_t;

  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_denorm(input logic [31:0] x);
    return (x[30:23] == 8'h00) && (x[22:0] != 23'd0);
  endfunction
endpackage

// File: rtl/fp32_div_if.sv
// Operand/result handshake bundle for the fp32 divider.
// Both sides use valid/ready. The master drives the operands and out_ready.
interface fp32_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/fp32_lzc24.sv
// Combinational 24-bit leading-zero counter. An all-zero input returns 24.
// Zero latency. No handshake.
module fp32_lzc24 (
  input  logic [23:0] i_dat,
  output logic [4:0]  o_cnt
);
  always_comb begin
    o_cnt = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (i_dat[i]) o_cnt = 5'(23 - i);
    end
  end
endmodule

// File: rtl/fp32_div.sv
// Iterative IEEE single divider (restoring, truncating). Normal operands take 28 cycles; special cases take 2.
// Accepts one operation at a time. The result is held in DONE until out_ready.
module fp32_div
  import fp32_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  fp32_div_if.slave  bus
);
  state_t             r_state, w_next;
  logic [31:0]        r_a, r_b, r_result, r_spec;
  logic [23:0]        r_mb;
  logic [24:0]        r_rem;
  logic [25:0]        r_q;
  logic signed [10:0] r_e;
  logic               r_sign, r_is_spec;
  logic [4:0]         r_cnt;

  logic [4:0]         w_lzc_a, w_lzc_b;
  logic [23:0]        w_ma, w_mb;
  logic signed [10:0] w_ea, w_eb, w_e;
  logic               w_s, w_is_spec;
  logic [31:0]        w_spec;
  logic               w_ge;
  logic [24:0]        w_sub;
  logic signed [10:0] w_exp_f, w_shift;
  logic [22:0]        w_mant;
  logic [23:0]        w_den;
  logic [31:0]        w_pack;
  logic               w_unused;

  fp32_lzc24 u_lzc_a (.i_dat({1'b0, r_a[22:0]}), .o_cnt(w_lzc_a));
  fp32_lzc24 u_lzc_b (.i_dat({1'b0, r_b[22:0]}), .o_cnt(w_lzc_b));

  // Denormals are shifted up to a leading 1 and their exponent is adjusted to match.
  always_comb begin
    w_s = r_a[31] ^ r_b[31];
    if (is_denorm(r_a)) begin
      w_ma = {1'b0, r_a[22:0]} << w_lzc_a;
      w_ea = 11'sd1 - $signed({6'd0, w_lzc_a});
    end else begin
      w_ma = {1'b1, r_a[22:0]};
      w_ea = $signed({3'd0, r_a[30:23]});
    end
    if (is_denorm(r_b)) begin
      w_mb = {1'b0, r_b[22:0]} << w_lzc_b;
      w_eb = 11'sd1 - $signed({6'd0, w_lzc_b});
    end else begin
      w_mb = {1'b1, r_b[22:0]};
      w_eb = $signed({3'd0, r_b[30:23]});
    end
    w_e = w_ea - w_eb + 11'sd127;
  end

  always_comb begin
    w_is_spec = 1'b1;
    w_spec    = QNAN;
    if (is_nan(r_a) || is_nan(r_b))          w_spec = QNAN;
    else if (is_inf(r_a) && is_inf(r_b))     w_spec = QNAN;
    else if (is_zero(r_a) && is_zero(r_b))   w_spec = QNAN;
    else if (is_inf(r_a) || is_zero(r_b))    w_spec = {w_s, POS_INF[30:0]};
    else if (is_zero(r_a) || is_inf(r_b))    w_spec = {w_s, 31'd0};
    else                                     w_is_spec = 1'b0;
  end

  assign w_ge  = r_rem >= {1'b0, r_mb};
  assign w_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  // A quotient of at least 1.0 lands in q[25], otherwise in q[24] with one less exponent.
  always_comb begin
    w_exp_f = r_q[25] ? r_e : (r_e - 11'sd1);
    w_mant  = r_q[25] ? r_q[24:2] : r_q[23:1];
    w_shift = 11'sd1 - w_exp_f;
    w_den   = {1'b1, w_mant} >> w_shift[4:0];
    if (r_is_spec)                w_pack = r_spec;
    else if (w_exp_f >= 11'sd255) w_pack = {r_sign, POS_INF[30:0]};
    else if (w_exp_f <= 11'sd0) begin
      if (w_shift >= 11'sd24)     w_pack = {r_sign, 31'd0};
      else                        w_pack = {r_sign, 8'd0, w_den[22:0]};
    end
    else                          w_pack = {r_sign, w_exp_f[7:0], w_mant};
  end

  assign w_unused = ^{r_q[0], w_sub[24], w_den[23]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.in_valid) w_next = S_PREP;
      S_PREP: w_next = w_is_spec ? S_PACK : S_DIV;
      S_DIV:  if (r_cnt == 5'd25) w_next = S_PACK;
      S_PACK: w_next = S_DONE;
      S_DONE: if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_spec    <= '0;
      r_mb      <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_e       <= '0;
      r_sign    <= 1'b0;
      r_is_spec <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_a <= bus.a;
          r_b <= bus.b;
        end
        S_PREP: begin
          r_mb      <= w_mb;
          r_rem     <= {1'b0, w_ma};
          r_q       <= '0;
          r_cnt     <= '0;
          r_e       <= w_e;
          r_sign    <= w_s;
          r_is_spec <= w_is_spec;
          r_spec    <= w_spec;
        end
        S_DIV: begin
          r_rem <= {w_sub[23:0], 1'b0};
          r_q   <= {r_q[24:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
        end
        S_PACK: r_result <= w_pack;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.result    = r_result;
endmodule

// File: tb/tb_fp32_div.sv
// Scoreboard bench for fp32_div: directed vectors, backpressure, back-to-back and async reset.
// Inputs are driven 1ns after the rising edge. The monitor samples on the falling edge.
module tb_fp32_div;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_pop = 0;
  logic prev_ov = 1'b0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  fp32_div_if bus();

  fp32_div dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp_v);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no event expected event within bound", nm);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) fail_now("unexpected_out_valid");
        else check({sb[0].nm, "_lat"}, 32'(cyc - sb[0].acc), 32'(sb[0].lat));
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        check({sb[0].nm, "_res"}, bus.result, sb[0].res);
        void'(sb.pop_front());
        last_pop = cyc;
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic issue(input string nm, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ev, input int lat, input bit hold, input bit b2b);
    int n;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      fail_now({nm, "_accept_timeout"});
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    sb.push_back('{ev, lat, cyc, nm});
    if (b2b) check({nm, "_b2b_gap"}, 32'(cyc - last_pop), 32'd2);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) fail_now({nm, "_drain_timeout"});
  endtask

  vec_t vecs[$];

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    vecs.push_back('{"six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 28});
    vecs.push_back('{"one_third",    32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 28});
    vecs.push_back('{"neg_sign",     32'hC1000000, 32'h3F000000, 32'hC1800000, 28});
    vecs.push_back('{"x_by_zero",    32'h3F800000, 32'h00000000, 32'h7F800000, 2});
    vecs.push_back('{"zero_zero",    32'h00000000, 32'h00000000, 32'h7FC00001, 2});
    vecs.push_back('{"inf_inf",      32'h7F800000, 32'h7F800000, 32'h7FC00001, 2});
    vecs.push_back('{"nan_in",       32'h7FC00000, 32'h3F800000, 32'h7FC00001, 2});
    vecs.push_back('{"inf_by_x",     32'hFF800000, 32'h40000000, 32'hFF800000, 2});
    vecs.push_back('{"zero_by_x",    32'h80000000, 32'h40000000, 32'h80000000, 2});
    vecs.push_back('{"x_by_inf",     32'h3F800000, 32'hFF800000, 32'h80000000, 2});
    vecs.push_back('{"overflow",     32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 28});
    vecs.push_back('{"denorm_out",   32'h00800000, 32'h40000000, 32'h00400000, 28});
    vecs.push_back('{"underflow",    32'h00000001, 32'h4B000000, 32'h00000000, 28});
    vecs.push_back('{"denorm_in",    32'h00400000, 32'h00800000, 32'h3F000000, 28});

    #12;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_result",    bus.result,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) issue(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat, 1'b0, 1'b0);
    drain("vectors");

    // Backpressure: hold the result for 10 cycles, then release it.
    bus.out_ready = 1'b0;
    issue("bp", 32'h40C00000, 32'h40000000, 32'h40400000, 28, 1'b0, 1'b0);
    begin
      int n;
      n = 0;
      while (!bus.out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) fail_now("bp_valid_timeout");
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold_result", bus.result, 32'h40400000);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    drain("bp");

    // Async reset in the middle of the division, while the division count is 13.
    issue("rst_op", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 28, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready",  32'(bus.in_ready),  32'd1);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_busy",      32'(bus.busy),      32'd0);
    check("arst_result",    bus.result,         32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 28, 1'b0, 1'b0);
    drain("post_rst");

    // Back-to-back operations with in_valid held high.
    issue("b2b_1", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 28, 1'b1, 1'b0);
    issue("b2b_2", 32'hC1000000, 32'h3F000000, 32'hC1800000, 28, 1'b0, 1'b1);
    drain("b2b");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
